// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared op encoding, FSM state type and op-class helpers for
//               seq_alu and its iterative multiply/divide engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // Base encodings keep their original values; M-extension ops are appended.
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } aluOperations;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } seq_alu_state_e;

    function automatic logic is_mul(input aluOperations op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic logic is_div(input aluOperations op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_muldiv(input aluOperations op);
        return is_mul(op) || is_div(op);
    endfunction

    function automatic logic is_signed_a(input aluOperations op);
        return op inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    endfunction

    function automatic logic is_signed_b(input aluOperations op);
        return op inside {ALU_MULH, ALU_DIV, ALU_REM};
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu_muldiv_iter.sv
// ============================================================================
// Module      : muldiv_iter
// Description : Radix-2 iterative engine: shift-add multiply and restoring
//               divide on magnitudes, with sign fix-up on the final step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              start_i,
    input  aluOperations      op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic              done_o,
    output logic [XLEN-1:0]   result_o
);

    localparam int              CNT_W    = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opb_q;
    logic              is_div_q;
    logic              hi_q;
    logic              rem_sel_q;
    logic              dbz_q;
    logic              neg_q;
    logic              neg_rem_q;

    logic              w_neg_a;
    logic              w_neg_b;
    logic              w_dbz;
    logic              w_start_div;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;

    assign w_neg_a     = is_signed_a(op_i) && a_i[XLEN-1];
    assign w_neg_b     = is_signed_b(op_i) && b_i[XLEN-1];
    assign w_mag_a     = w_neg_a ? -a_i : a_i;
    assign w_mag_b     = w_neg_b ? -b_i : b_i;
    assign w_dbz       = (b_i == '0);
    assign w_start_div = is_div(op_i);

    // Multiply: acc = {partial sum, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_tmp;
    logic              w_ge;
    logic [XLEN-1:0]   w_diff;
    logic [2*XLEN-1:0] w_step;

    always_comb begin
        w_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        w_tmp  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        w_ge   = (w_tmp >= {1'b0, opb_q});
        w_diff = w_tmp[XLEN-1:0] - opb_q;
        if (is_div_q) begin
            if (w_ge) begin
                w_step = {w_diff, acc_q[XLEN-2:0], 1'b1};
            end else begin
                w_step = {w_tmp[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            w_step = {w_sum, acc_q[XLEN-1:1]};
        end
    end

    // Result is formed from the last step so it lands in the same edge as DONE.
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;

    always_comb begin
        w_prod = neg_q ? -w_step : w_step;
        w_quo  = w_step[XLEN-1:0];
        w_rem  = w_step[2*XLEN-1:XLEN];
        if (is_div_q) begin
            if (rem_sel_q) begin
                result_o = neg_rem_q ? -w_rem : w_rem;
            end else if (dbz_q) begin
                result_o = '1;
            end else begin
                result_o = neg_q ? -w_quo : w_quo;
            end
        end else begin
            result_o = hi_q ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
        end
    end

    assign done_o = (cnt_q == CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            hi_q      <= 1'b0;
            rem_sel_q <= 1'b0;
            dbz_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (flush_i) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q     <= CNT_INIT;
            is_div_q  <= w_start_div;
            hi_q      <= (op_i != ALU_MUL);
            rem_sel_q <= (op_i == ALU_REM) || (op_i == ALU_REMU);
            dbz_q     <= w_dbz;
            neg_rem_q <= w_neg_a;
            if (w_start_div) begin
                neg_q <= (w_neg_a ^ w_neg_b) && !w_dbz;
                acc_q <= {{XLEN{1'b0}}, w_mag_a};
                opb_q <= w_mag_b;
            end else begin
                neg_q <= w_neg_a ^ w_neg_b;
                acc_q <= {{XLEN{1'b0}}, w_mag_b};
                opb_q <= w_mag_a;
            end
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
            acc_q <= w_step;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module      : seq_alu
// Description : Handshaked RV32I/RV64I ALU with iterative M-extension ops.
//               Build option SEQ_ALU_FAST_MUL_EN: single-cycle multiplies.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  aluOperations      operation,
    input  logic [XLEN-1:0]   data1,
    input  logic [XLEN-1:0]   data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   outputData,
    output logic              busy
);

    localparam int SHAMT_W = $clog2(XLEN);

    seq_alu_state_e  state_q, state_d;
    logic [XLEN-1:0] out_q, out_d;

    logic [SHAMT_W-1:0] w_shamt;
    logic [XLEN-1:0]    w_base;
    logic               w_iter;
    logic               w_start;
    logic               w_md_done;
    logic [XLEN-1:0]    w_md_result;

    assign w_shamt = data2[SHAMT_W-1:0];

`ifdef SEQ_ALU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fa;
    logic [2*XLEN-1:0] w_fb;
    logic [2*XLEN-1:0] w_fprod;

    // Sign-extending both to 2*XLEN makes the low 2*XLEN product bits exact
    // for every signedness combination.
    assign w_fa    = is_signed_a(operation) ? {{XLEN{data1[XLEN-1]}}, data1}
                                            : {{XLEN{1'b0}}, data1};
    assign w_fb    = is_signed_b(operation) ? {{XLEN{data2[XLEN-1]}}, data2}
                                            : {{XLEN{1'b0}}, data2};
    assign w_fprod = w_fa * w_fb;
    assign w_iter  = is_div(operation);
`else
    assign w_iter  = is_muldiv(operation);
`endif

    always_comb begin
        w_base = '0;
        case (operation)
            ALU_ADD:  w_base = data1 + data2;
            ALU_SUB:  w_base = data1 - data2;
            ALU_SLL:  w_base = data1 << w_shamt;
            ALU_SLT:  w_base = {{(XLEN-1){1'b0}}, ($signed(data1) < $signed(data2))};
            ALU_SLTU: w_base = {{(XLEN-1){1'b0}}, (data1 < data2)};
            ALU_XOR:  w_base = data1 ^ data2;
            ALU_SRL:  w_base = data1 >> w_shamt;
            ALU_SRA:  w_base = $signed(data1) >>> w_shamt;
            ALU_OR:   w_base = data1 | data2;
            ALU_AND:  w_base = data1 & data2;
`ifdef SEQ_ALU_FAST_MUL_EN
            ALU_MUL:    w_base = w_fprod[XLEN-1:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  w_base = w_fprod[2*XLEN-1:XLEN];
`endif
            default:  w_base = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        w_start = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (w_iter) begin
                            w_start = 1'b1;
                            state_d = BUSY;
                        end else begin
                            out_d   = w_base;
                            state_d = DONE;
                        end
                    end
                end
                BUSY: begin
                    if (w_md_done) begin
                        out_d   = w_md_result;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .start_i  (w_start),
        .op_i     (operation),
        .a_i      (data1),
        .b_i      (data2),
        .done_o   (w_md_done),
        .result_o (w_md_result)
    );

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign outputData = out_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu (XLEN=32) against a
//               latency/result reference model built from plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;
    import alu_pkg::*;

    localparam int XLEN = 32;
`ifdef SEQ_ALU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         flush     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    aluOperations operation = ALU_ADD;
    logic [31:0]  data1     = '0;
    logic [31:0]  data2     = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [31:0]  outputData;

    always #5 clk = ~clk;

    seq_alu #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operation  (operation),
        .data1      (data1),
        .data2      (data2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .outputData (outputData),
        .busy       (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, p;
        logic [63:0] uu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        uu = {32'd0, a} * {32'd0, b};
        case (op)
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_SLL:    return a << b[4:0];
            ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:    return a ^ b;
            ALU_SRL:    return a >> b[4:0];
            ALU_SRA:    return 32'(sa >>> b[4:0]);
            ALU_OR:     return a | b;
            ALU_AND:    return a & b;
            ALU_MUL:    return 32'(sa * sb);
            ALU_MULH:   begin p = sa * sb; return 32'(p >>> 32); end
            ALU_MULHSU: begin p = sa * longint'({32'd0, b}); return 32'(p >>> 32); end
            ALU_MULHU:  return uu[63:32];
            ALU_DIV:    return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM:    return (b == 0) ? a : 32'(sa % sb);
            ALU_REMU:   return (b == 0) ? a : a % b;
            default:    return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] op);
        if (op >= ALU_MUL && op <= ALU_MULHU) return MUL_LAT;
        if (op >= ALU_DIV && op <= ALU_REMU) return XLEN + 1;
        return 1;
    endfunction

    // Model: idle / counting down to result / holding result.
    bit          m_pend  = 1'b0;
    bit          m_valid = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] m_data  = '0;
    logic [31:0] m_res   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 1'b0; m_valid = 1'b0; m_cnt = 0; m_data = '0;
        end else if (flush) begin
            m_pend = 1'b0; m_valid = 1'b0;
        end else if (m_pend) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_pend = 1'b0; m_valid = 1'b1; m_data = m_res;
            end
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (in_valid) begin
            m_res = ref_res(operation, data1, data2);
            if (ref_lat(operation) == 1) begin
                m_valid = 1'b1; m_data = m_res;
            end else begin
                m_pend = 1'b1; m_cnt = ref_lat(operation) - 1;
            end
        end
    end

    // Single compare process, every cycle.
    always @(negedge clk) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("in_ready",  {31'd0, in_ready},  {31'd0, !(m_pend || m_valid)});
        chk("busy",      {31'd0, busy},      {31'd0, (m_pend || m_valid)});
        if (m_valid) chk("outputData", outputData, m_data);
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        int w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) timeout("wait_in_ready");
    endtask

    task automatic start_op(input aluOperations op, input logic [31:0] a, input logic [31:0] b);
        wait_ready();
        in_valid = 1'b1; operation = op; data1 = a; data2 = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_op(input aluOperations op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit lit, input logic [31:0] exp_v,
                         input int exp_lat, input string nm);
        int lat = 0;
        out_ready = 1'b0;
        start_op(op, a, b);
        lat = 1;
        while (!out_valid && lat < 100) begin
            // Stray requests and operand churn while busy must be ignored.
            in_valid  = 1'($urandom_range(0, 1));
            operation = aluOperations'(5'($urandom_range(0, 17)));
            data1     = $urandom;
            data2     = $urandom;
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            timeout({nm, "_result"});
        end else if (lit) begin
            chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
            chk(nm, outputData, exp_v);
        end
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputData", outputData, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(ALU_ADD,    32'd7,         32'd5,         0, 1, 32'd12,        1,       "add_7_5");
        do_op(ALU_SRA,    32'hF000_0000, 32'h24,        0, 1, 32'hFF00_0000, 1,       "sra");
        do_op(ALU_SLT,    32'hFFFF_FFFF, 32'd1,         0, 1, 32'd1,         1,       "slt");
        do_op(ALU_SLTU,   32'hFFFF_FFFF, 32'd1,         0, 1, 32'd0,         1,       "sltu");
        do_op(ALU_MULH,   32'h8000_0000, 32'h8000_0000, 0, 1, 32'h4000_0000, MUL_LAT, "mulh");
        do_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFF, MUL_LAT, "mulhsu");
        do_op(ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h8000_0000, 33,      "div_ovf");
        do_op(ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'd0,         33,      "rem_ovf");
        do_op(ALU_REM,    32'hFFFF_FFF9, 32'd2,         0, 1, 32'hFFFF_FFFF, 33,      "rem_m7_2");
        do_op(ALU_DIVU,   32'd100,       32'd0,         0, 1, 32'hFFFF_FFFF, 33,      "divu_0");
        do_op(ALU_REMU,   32'd100,       32'd0,         0, 1, 32'd100,       33,      "remu_0");
        do_op(ALU_ADD,    32'd1,         32'd1,         5, 1, 32'd2,         1,       "add_bp");
        do_op(aluOperations'(5'd25), 32'd3, 32'd4,      0, 1, 32'd0,         1,       "unknown_op");

        // Reset in the middle of a divide.
        start_op(ALU_DIVU, 32'd1000, 32'd7);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Flush in the middle of a divide.
        start_op(ALU_DIVU, 32'd1000, 32'd7);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("abort_flush_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (40) @(negedge clk);

        // Flush beats a simultaneous request.
        in_valid = 1'b1; operation = ALU_ADD; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_prio_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 250; i++) begin
            int r;
            aluOperations op;
            r  = $urandom_range(0, 19);
            op = (r < 18) ? aluOperations'(5'(r)) : aluOperations'(5'($urandom_range(18, 31)));
            do_op(op, pick_val(), pick_val(), $urandom_range(0, 3), 1'b0, 32'd0, 0, "rand");
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
